// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin arbiter feeding one shared serial pattern detector.
// Optional per-channel match counters: define SEQ_DET_SCHED_MATCH_CNT_EN.
module seq_det_sched #(
  parameter int              NCH     = 4,
  parameter int              PW      = 4,
  parameter logic [PW-1:0]   PATTERN = 4'b1011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           bit_in,
  input  logic [NCH-1:0]           flush,
  output logic [NCH-1:0]           gnt,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch,
  output logic [NCH-1:0]           busy
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  ,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  input  logic                     cnt_clr,
  output logic [7:0]               cnt_out
`endif
);

  localparam int CW = $clog2(NCH);
  localparam int FW = $clog2(PW);
  localparam logic [FW-1:0] FMAX = FW'(PW - 1);

  logic [CW-1:0] r_ptr;
  logic [PW-2:0] r_hist [NCH];
  logic [FW-1:0] r_fill [NCH];
  logic [NCH-1:0] r_busy;
  logic          r_mv;
  logic [CW-1:0] r_mch;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_gnt;
  logic [CW-1:0]  w_win;
  logic [CW-1:0]  w_idx;
  logic           w_any;
  logic           w_match;
  logic [PW-1:0]  w_sh  [NCH];
  logic [FW-1:0]  w_fnx [NCH];

  always_comb begin
    w_elig = req & ~flush;
    if (rst) w_elig = '0;
    w_gnt = '0;
    w_win = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = CW'((int'(r_ptr) + i) % NCH);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_sh[c]  = {r_hist[c], bit_in[c]};
      w_fnx[c] = r_fill[c];
      if (flush[c])
        w_fnx[c] = '0;
      else if (w_gnt[c] && r_fill[c] != FMAX)
        w_fnx[c] = r_fill[c] + FW'(1);
    end
  end

  // overlap falls out naturally: history keeps shifting after a match
  assign w_match = w_any
                && (r_fill[w_win] == FMAX)
                && (w_sh[w_win] == PATTERN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_mv   <= 1'b0;
      r_mch  <= '0;
      r_busy <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_hist[c] <= '0;
        r_fill[c] <= '0;
      end
    end else begin
      if (w_any) r_ptr <= CW'((int'(w_win) + 1) % NCH);
      r_mv <= w_match;
      if (w_match) r_mch <= w_win;
      for (int c = 0; c < NCH; c++) begin
        if (flush[c])
          r_hist[c] <= '0;
        else if (w_gnt[c])
          r_hist[c] <= w_sh[c][PW-2:0];
        r_fill[c] <= w_fnx[c];
        r_busy[c] <= (w_fnx[c] != '0);
      end
    end
  end

  assign gnt         = w_gnt;
  assign match_valid = r_mv;
  assign match_ch    = r_mch;
  assign busy        = r_busy;

`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  logic [7:0] r_cnt [NCH];

  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
    end else if (w_match && r_cnt[w_win] != 8'hFF) begin
      r_cnt[w_win] <= r_cnt[w_win] + 8'd1;
    end
  end

  assign cnt_out = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized scoreboard bench for seq_det_sched against a bit-count model.
// Also exercises the SEQ_DET_SCHED_MATCH_CNT_EN counters when defined.
module tb_seq_det_sched;

  localparam int NCH = 4;
  localparam int PW  = 4;
  localparam int CW  = $clog2(NCH);
  localparam logic [PW-1:0] PAT = 4'b1011;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req, bit_in, flush;
  logic [NCH-1:0] gnt, busy;
  logic           match_valid;
  logic [CW-1:0]  match_ch;
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
  logic [CW-1:0]  cnt_sel = '0;
  logic           cnt_clr = 1'b0;
  logic [7:0]     cnt_out;
`endif

  seq_det_sched #(.NCH(NCH), .PW(PW), .PATTERN(PAT)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in),
    .flush(flush), .gnt(gnt), .match_valid(match_valid),
    .match_ch(match_ch), .busy(busy)
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model: bits seen since last clear, plus the raw shifted bit value
  int          ptr = 0;
  int          nb [NCH];
  int unsigned hv [NCH];
  int          mcnt [NCH];

  typedef struct { int cyc; int ch; bit is_rst; } exp_t;
  exp_t q[$];
  int   hold_ch = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    ptr = 0;
    for (int c = 0; c < NCH; c++) begin
      nb[c] = 0; hv[c] = 0; mcnt[c] = 0;
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] rq,
                      input logic [NCH-1:0] b, input logic [NCH-1:0] f);
    int g;
    int c;
    logic [NCH-1:0] eg, eb;
    bit m;
    rst = r; req = rq; bit_in = b; flush = f;
    @(negedge clk);
    g = -1;
    if (!r)
      for (int i = 0; i < NCH; i++) begin
        c = (ptr + i) % NCH;
        if (g < 0 && rq[c] && !f[c]) g = c;
      end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    eb = '0;
    for (int k = 0; k < NCH; k++) eb[k] = (nb[k] != 0);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    chk("cnt_out", 32'(cnt_out), 32'(mcnt[cnt_sel]));
`endif
    m = 1'b0;
    if (r) begin
      model_clear();
      q.push_back('{cyc + 1, 0, 1'b1});
    end else begin
      for (int k = 0; k < NCH; k++)
        if (f[k]) begin
          nb[k] = 0; hv[k] = 0;
        end else if (k == g) begin
          hv[k] = (hv[k] << 1) | int'(b[k]);
          nb[k]++;
          if (nb[k] >= PW && (hv[k] & ((1 << PW) - 1)) == int'(PAT)) begin
            m = 1'b1;
            q.push_back('{cyc + 1, k, 1'b0});
          end
        end
      if (g >= 0) ptr = (g + 1) % NCH;
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
      if (cnt_clr)
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
      else if (m && mcnt[g] < 255)
        mcnt[g]++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic bv);
    logic [NCH-1:0] rq, bb;
    rq = '0; bb = '0;
    rq[ch] = 1'b1; bb[ch] = bv;
    step(1'b0, rq, bb, '0);
  endtask

  task automatic flush_all();
    step(1'b0, '0, '0, '1);
  endtask

  always @(negedge clk) begin
    bit got;
    got = 1'b0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL stale_expect: got cycle %0d expected cycle %0d",
                 cyc, e.cyc);
      end else if (e.is_rst) begin
        hold_ch = 0;
      end else begin
        got = 1'b1;
        chk("match_valid", 32'(match_valid), 32'd1);
        chk("match_ch", 32'(match_ch), 32'(e.ch));
        hold_ch = e.ch;
      end
    end
    if (!got && cyc > 0) begin
      chk("no_match", 32'(match_valid), 32'd0);
      chk("match_hold", 32'(match_ch), 32'(hold_ch));
    end
  end

  logic [NCH-1:0] rr, rb, rf;

  initial begin
    model_clear();
    rst = 1'b1; req = '0; bit_in = '0; flush = '0;
    #1;
    step(1'b1, '1, '1, '0);
    step(1'b1, '0, '0, '0);
    @(negedge clk);
    chk("rst_mv", 32'(match_valid), 32'd0);
    chk("rst_mch", 32'(match_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    send(0, 1); send(0, 0); send(0, 1); send(0, 1);
    step(1'b0, '0, '0, '0);
    flush_all();
    send(0, 1); send(0, 0); send(0, 1); send(0, 1);
    send(0, 0); send(0, 1); send(0, 1);
    step(1'b0, '0, '0, '0);

    for (int i = 0; i < 8; i++) step(1'b0, '1, NCH'($urandom), '0);
    step(1'b1, '0, '0, '0);
    step(1'b0, 4'b1010, '1, '0);
    step(1'b0, 4'b1010, '1, '0);

    flush_all();
    send(2, 1); send(1, 1); send(2, 0); send(1, 1);
    send(2, 1); send(2, 1);
    step(1'b0, '0, '0, '0);

    flush_all();
    send(3, 1); send(3, 0); send(3, 1);
    step(1'b0, 4'b1000, 4'b1000, 4'b1000);
    send(3, 1);

    send(0, 1); send(0, 0); send(0, 1);
    step(1'b1, '1, '1, '0);
    send(0, 1);

    for (int i = 0; i < 3000; i++) begin
      rr = NCH'($urandom);
      rb = NCH'($urandom);
      rf = '0;
      for (int k = 0; k < NCH; k++) rf[k] = ($urandom_range(0, 15) == 0);
`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
      cnt_sel = CW'($urandom_range(0, NCH - 1));
      cnt_clr = ($urandom_range(0, 299) == 0);
`endif
      step($urandom_range(0, 199) == 0, rr, rb, rf);
    end

`ifdef SEQ_DET_SCHED_MATCH_CNT_EN
    cnt_clr = 1'b0;
    cnt_sel = CW'(1);
    flush_all();
    for (int i = 0; i < 300; i++) begin
      send(1, 1); send(1, 0); send(1, 1); send(1, 1);
    end
    step(1'b0, '0, '0, '0);
    chk("cnt_sat", 32'(cnt_out), 32'd255);
    send(1, 1); send(1, 0); send(1, 1);
    cnt_clr = 1'b1;
    send(1, 1);
    cnt_clr = 1'b0;
    step(1'b0, '0, '0, '0);
    chk("cnt_clr_win", 32'(cnt_out), 32'd0);
`endif

    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
